// File: rtl/tm1640_pkg.sv
// Shared definitions for the TM1640 refresh sequencer: FSM encoding, command
// bytes, display-buffer geometry and the display-control byte builder.
package tm1640_pkg;

  localparam int BYTE_W    = 8;
  localparam int GRID_AW   = 4;
  localparam int MAX_GRIDS = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LAT_CMD   = 3'd1;
  localparam state_t ST_WAIT_CMD  = 3'd2;
  localparam state_t ST_LAT_ADDR  = 3'd3;
  localparam state_t ST_STREAM    = 3'd4;
  localparam state_t ST_LAT_CTRL  = 3'd5;
  localparam state_t ST_WAIT_CTRL = 3'd6;
  localparam state_t ST_HOLDOFF   = 3'd7;

  localparam logic [BYTE_W-1:0] CMD_DATA      = 8'h40;
  localparam logic [BYTE_W-1:0] CMD_ADDR0     = 8'hC0;
  localparam logic [BYTE_W-1:0] CMD_CTRL_BASE = 8'h80;

  // Byte offered to the driver together with its stop-after flag.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              stop;
  } tm_byte_t;

  function automatic logic [BYTE_W-1:0] ctrl_byte(input logic disp_on,
                                                  input logic [2:0] level);
    return CMD_CTRL_BASE | {4'b0000, disp_on, level};
  endfunction

endpackage

// File: rtl/tm1640_refresh_ctrl_if.sv
// Latch/busy byte handshake between the refresh sequencer (master) and the
// TM1640 serial byte driver (slave).
interface tm1640_refresh_ctrl_if;
  import tm1640_pkg::*;

  logic              tm_latch;
  logic [BYTE_W-1:0] tm_data;
  logic              tm_stop;
  logic              tm_busy;

  modport master (output tm_latch, output tm_data, output tm_stop, input tm_busy);
  modport slave  (input tm_latch, input tm_data, input tm_stop, output tm_busy);

endinterface

// File: rtl/tm1640_disp_buf.sv
// Grid segment buffer with one write port and an asynchronous read port.
// With TM1640_SHADOW_EN defined a shadow bank snapshots the live bank on i_copy.
module tm1640_disp_buf
  import tm1640_pkg::*;
#(
  parameter int NUM_GRIDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_en,
  input  logic [GRID_AW-1:0] i_wr_addr,
  input  logic [BYTE_W-1:0]  i_wr_data,
  input  logic               i_copy,
  input  logic [GRID_AW-1:0] i_rd_addr,
  output logic [BYTE_W-1:0]  o_rd_data
);

  localparam logic [GRID_AW:0] NG = (GRID_AW+1)'(NUM_GRIDS);

  logic [BYTE_W-1:0] r_live [MAX_GRIDS];
  logic              w_wr_ok;

  // Writes beyond the configured grid count are dropped.
  assign w_wr_ok = i_wr_en & ({1'b0, i_wr_addr} < NG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_GRIDS; i++) r_live[i] <= '0;
    end else if (w_wr_ok) begin
      r_live[i_wr_addr] <= i_wr_data;
    end
  end

`ifdef TM1640_SHADOW_EN
  logic [BYTE_W-1:0] r_shadow [MAX_GRIDS];

  // The copy takes the pre-write live contents, so a same-cycle write waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_GRIDS; i++) r_shadow[i] <= '0;
    end else if (i_copy) begin
      r_shadow <= r_live;
    end
  end

  assign o_rd_data = r_shadow[i_rd_addr];
`else
  logic w_unused_copy;
  assign w_unused_copy = i_copy;
  assign o_rd_data     = r_live[i_rd_addr];
`endif

endmodule

// File: rtl/tm1640_refresh_ctrl.sv
// TM1640 frame sequencer: streams data cmd, address cmd + grid bytes and display
// control through the driver handshake, then holds off. TM1640_SHADOW_EN adds a shadow bank.
module tm1640_refresh_ctrl
  import tm1640_pkg::*;
#(
  parameter int          NUM_GRIDS   = 16,
  parameter int          REFRESH_DIV = 120000,
  parameter logic [7:0]  CMD_DATA    = 8'h40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2:0]           brightness,
  input  logic                 display_on,
  input  logic                 wr_en,
  input  logic [GRID_AW-1:0]   wr_addr,
  input  logic [BYTE_W-1:0]    wr_data,
  tm1640_refresh_ctrl_if.master drv,
  output logic                 active,
  output logic                 frame_done
);

  localparam int                 CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(REFRESH_DIV - 1);
  localparam logic [GRID_AW-1:0] LAST_IDX  = GRID_AW'(NUM_GRIDS - 1);

  state_t             r_state;
  logic               r_busy_q;
  logic               r_last_stop;
  logic               r_frame_done;
  logic [GRID_AW-1:0] r_idx;
  logic [CNT_W-1:0]   r_hold;
  logic [BYTE_W-1:0]  r_ctrl;

  logic               w_busy_fall;
  logic               w_done;
  logic               w_latch;
  logic               w_copy;
  logic [BYTE_W-1:0]  w_grid;
  tm_byte_t           w_pres;

  // r_last_stop tracks the stop flag of the byte the driver currently owns.
  assign w_busy_fall = r_busy_q & ~drv.tm_busy;
  assign w_done      = w_busy_fall & r_last_stop;
  assign w_copy      = (r_state == ST_LAT_CMD) & w_latch;

  tm1640_disp_buf #(
    .NUM_GRIDS (NUM_GRIDS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_copy    (w_copy),
    .i_rd_addr (r_idx),
    .o_rd_data (w_grid)
  );

  always_comb begin
    w_pres  = '0;
    w_latch = 1'b0;
    case (r_state)
      ST_LAT_CMD: begin
        w_pres.data = CMD_DATA;
        w_pres.stop = 1'b1;
        w_latch     = ~drv.tm_busy;
      end
      ST_WAIT_CMD: begin
        w_pres.data = CMD_DATA;
        w_pres.stop = 1'b1;
      end
      ST_LAT_ADDR: begin
        w_pres.data = CMD_ADDR0;
        w_pres.stop = 1'b0;
        w_latch     = ~drv.tm_busy;
      end
      ST_STREAM: begin
        w_pres.data = w_grid;
        w_pres.stop = (r_idx == LAST_IDX);
      end
      ST_LAT_CTRL: begin
        w_pres.data = ctrl_byte(display_on, brightness);
        w_pres.stop = 1'b1;
        w_latch     = ~drv.tm_busy;
      end
      ST_WAIT_CTRL: begin
        w_pres.data = r_ctrl;
        w_pres.stop = 1'b1;
      end
      default: ;
    endcase
  end

  assign drv.tm_latch = w_latch;
  assign drv.tm_data  = w_pres.data;
  assign drv.tm_stop  = w_pres.stop;
  assign active       = (r_state != ST_IDLE) && (r_state != ST_HOLDOFF);
  assign frame_done   = r_frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_busy_q     <= 1'b0;
      r_last_stop  <= 1'b0;
      r_frame_done <= 1'b0;
      r_idx        <= '0;
      r_hold       <= '0;
    end else begin
      r_busy_q     <= drv.tm_busy;
      r_frame_done <= 1'b0;
      if (w_latch) r_last_stop <= w_pres.stop;
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_LAT_CMD;
        end
        ST_LAT_CMD: begin
          if (w_latch) r_state <= ST_WAIT_CMD;
        end
        ST_WAIT_CMD: begin
          if (w_done) r_state <= ST_LAT_ADDR;
        end
        ST_LAT_ADDR: begin
          if (w_latch) begin
            r_idx   <= '0;
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // A busy fall either completes the stop byte or fetches the presented grid byte.
          if (w_done) begin
            r_state <= ST_LAT_CTRL;
          end else if (w_busy_fall) begin
            r_last_stop <= w_pres.stop;
            if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
          end
        end
        ST_LAT_CTRL: begin
          if (w_latch) r_state <= ST_WAIT_CTRL;
        end
        ST_WAIT_CTRL: begin
          if (w_done) begin
            r_frame_done <= 1'b1;
            r_hold       <= HOLD_LOAD;
            r_state      <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (r_hold == '0) r_state <= enable ? ST_LAT_CMD : ST_IDLE;
          else              r_hold  <= r_hold - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Control byte is frozen at latch time so brightness changes cannot glitch it.
  always_ff @(posedge clk) begin
    if (w_latch && (r_state == ST_LAT_CTRL)) r_ctrl <= w_pres.data;
  end

endmodule

// File: tb/tb_tm1640_refresh_ctrl.sv
// Bench for tm1640_refresh_ctrl: byte-driver model feeding a scoreboard, a
// table of frame vectors, and hand-written multi-cycle sequences.
module tb_tm1640_refresh_ctrl;
  import tm1640_pkg::*;

  localparam logic [3:0] BYTE_CYC = 4'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en0, en1, display_on, wr_en;
  logic [2:0] brightness;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       act0, act1, fd0, fd1;

  always #5 clk = ~clk;

  tm1640_refresh_ctrl_if drv0 ();
  tm1640_refresh_ctrl_if drv1 ();

  tm1640_refresh_ctrl #(.NUM_GRIDS(16), .REFRESH_DIV(50), .CMD_DATA(8'h40)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .brightness(brightness), .display_on(display_on),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .drv(drv0),
    .active(act0), .frame_done(fd0));

  tm1640_refresh_ctrl #(.NUM_GRIDS(1), .REFRESH_DIV(3), .CMD_DATA(8'h40)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .brightness(brightness), .display_on(display_on),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .drv(drv1),
    .active(act1), .frame_done(fd1));

  // ---------------- byte driver model ----------------
  typedef struct packed {
    logic       act;
    logic       busy;
    logic [3:0] cnt;
    logic       stop;
  } drv_t;

  function automatic void drv_step(input drv_t s, input logic latch, input logic [8:0] pres,
                                   output drv_t n, output logic got, output logic viol);
    n    = s;
    got  = 1'b0;
    viol = 1'b0;
    if (!s.act) begin
      if (latch) begin
        got = 1'b1; n.act = 1'b1; n.busy = 1'b1; n.cnt = BYTE_CYC; n.stop = pres[0];
      end
    end else begin
      viol = latch;
      if (s.busy) begin
        if (s.cnt != 4'd0) n.cnt = s.cnt - 4'd1;
        else begin
          n.busy = 1'b0;
          n.act  = ~s.stop;
        end
      end else begin
        got = 1'b1; n.busy = 1'b1; n.cnt = BYTE_CYC; n.stop = pres[0];
      end
    end
  endfunction

  drv_t       m0 = '0, m1 = '0;
  int         cyc = 0;
  int         wp0 = 0, wp1 = 0, lat0 = 0, lat1 = 0, fdn0 = 0, fdn1 = 0, viol0 = 0, viol1 = 0;
  logic [8:0] obs0 [1024];
  logic [8:0] obs1 [1024];
  int         lat_cyc0 [64];
  int         fd_cyc0 [64];

  assign drv0.tm_busy = m0.busy;
  assign drv1.tm_busy = m1.busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin : model0
    drv_t n;
    logic got, v;
    if (rst) m0 <= '0;
    else begin
      drv_step(m0, drv0.tm_latch, {drv0.tm_data, drv0.tm_stop}, n, got, v);
      m0 <= n;
      if (got) begin obs0[wp0 & 1023] <= {drv0.tm_data, drv0.tm_stop}; wp0 <= wp0 + 1; end
      if (v) viol0 <= viol0 + 1;
      if (drv0.tm_latch) begin if (lat0 < 64) lat_cyc0[lat0] <= cyc; lat0 <= lat0 + 1; end
      if (fd0) begin if (fdn0 < 64) fd_cyc0[fdn0] <= cyc; fdn0 <= fdn0 + 1; end
    end
  end

  always @(posedge clk) begin : model1
    drv_t n;
    logic got, v;
    if (rst) m1 <= '0;
    else begin
      drv_step(m1, drv1.tm_latch, {drv1.tm_data, drv1.tm_stop}, n, got, v);
      m1 <= n;
      if (got) begin obs1[wp1 & 1023] <= {drv1.tm_data, drv1.tm_stop}; wp1 <= wp1 + 1; end
      if (v) viol1 <= viol1 + 1;
      if (drv1.tm_latch) lat1 <= lat1 + 1;
      if (fd1) fdn1 <= fdn1 + 1;
    end
  end

  // ---------------- scoreboard and helpers ----------------
  int         errors = 0, checks = 0;
  int         rp0 = 0, rp1 = 0;
  logic [8:0] exp_q [$];
  logic [7:0] gm [16];
  logic [7:0] ga [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    gm[a] = d;
  endtask

  task automatic push_frame(input int ng, input logic [7:0] g [16], input logic [7:0] ctrl);
    exp_q.push_back({8'h40, 1'b1});
    exp_q.push_back({8'hC0, 1'b0});
    for (int i = 0; i < ng; i++) exp_q.push_back({g[i], (i == ng - 1)});
    exp_q.push_back({ctrl, 1'b1});
  endtask

  task automatic wait_rx(input int inst, input int n, input string tag);
    int budget;
    budget = 0;
    while ((((inst == 0) ? (wp0 - rp0) : (wp1 - rp1)) < n) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 3000) begin
      checks++; errors++;
      $display("FAIL %s timeout: received %0d bytes, want %0d", tag,
               (inst == 0) ? (wp0 - rp0) : (wp1 - rp1), n);
    end
  endtask

  task automatic drain(input int inst, input string tag);
    int         k, budget;
    logic [8:0] got_b, exp_b;
    k = 0;
    while (exp_q.size() != 0) begin
      budget = 0;
      while ((((inst == 0) ? (wp0 - rp0) : (wp1 - rp1)) <= 0) && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 3000) begin
        checks++; errors++;
        $display("FAIL %s timeout: got %0d bytes, want %0d more", tag, k, exp_q.size());
        exp_q.delete();
        return;
      end
      if (inst == 0) begin got_b = obs0[rp0 & 1023]; rp0++; end
      else           begin got_b = obs1[rp1 & 1023]; rp1++; end
      exp_b = exp_q.pop_front();
      check($sformatf("%s byte%0d", tag, k), {23'd0, got_b}, {23'd0, exp_b});
      k++;
    end
  endtask

  typedef struct {
    logic [7:0] fill;
    logic [2:0] br;
    logic       on;
    logic [7:0] exp_ctrl;
  } vec_t;

  vec_t vt [4];

  initial begin
    int base_l, base_f;
    vt[0] = '{8'h00, 3'd7, 1'b1, 8'h8F};
    vt[1] = '{8'h5A, 3'd0, 1'b0, 8'h80};
    vt[2] = '{8'hFF, 3'd3, 1'b1, 8'h8B};
    vt[3] = '{8'h81, 3'd5, 1'b0, 8'h85};
    for (int i = 0; i < 16; i++) gm[i] = 8'h00;
    en0 = 1'b0; en1 = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    brightness = '0; display_on = 1'b0;

    repeat (3) @(negedge clk);
    check("reset latch", {31'd0, drv0.tm_latch}, 32'd0);
    check("reset data", {24'd0, drv0.tm_data}, 32'd0);
    check("reset stop", {31'd0, drv0.tm_stop}, 32'd0);
    check("reset active", {31'd0, act0}, 32'd0);
    check("reset frame_done", {31'd0, fd0}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle after reset", {31'd0, act0}, 32'd0);

    // Table-driven full frames: buffer pattern, brightness, display_on.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i + 1) ^ vt[v].fill);
      brightness = vt[v].br;
      display_on = vt[v].on;
      base_l = lat0; base_f = fdn0;
      push_frame(16, gm, vt[v].exp_ctrl);
      en0 = 1'b1;
      @(negedge clk);
      en0 = 1'b0;
      drain(0, $sformatf("vec%0d", v));
      repeat (80) @(negedge clk);
      check($sformatf("vec%0d latches", v), lat0 - base_l, 3);
      check($sformatf("vec%0d frame_done", v), fdn0 - base_f, 1);
      check($sformatf("vec%0d idle", v), {31'd0, act0}, 32'd0);
    end

    // Back-to-back frames: next data command 50 cycles after frame_done.
    base_l = lat0; base_f = fdn0;
    push_frame(16, gm, 8'h85);
    push_frame(16, gm, 8'h85);
    en0 = 1'b1;
    drain(0, "refresh");
    en0 = 1'b0;
    repeat (80) @(negedge clk);
    check("refresh latches", lat0 - base_l, 6);
    check("refresh frame_done", fdn0 - base_f, 2);
    if (lat0 - base_l >= 4 && fdn0 - base_f >= 1)
      check("refresh holdoff", lat_cyc0[base_l + 3] - fd_cyc0[base_f], 50);

    // enable drops while grid 5 is in flight: frame still completes.
    brightness = 3'd7; display_on = 1'b1;
    base_l = lat0; base_f = fdn0;
    push_frame(16, gm, 8'h8F);
    en0 = 1'b1;
    wait_rx(0, 7, "drop wait");
    en0 = 1'b0;
    @(negedge clk);
    check("drop active mid-frame", {31'd0, act0}, 32'd1);
    drain(0, "drop");
    repeat (80) @(negedge clk);
    check("drop latches", lat0 - base_l, 3);
    check("drop frame_done", fdn0 - base_f, 1);
    check("drop idle", {31'd0, act0}, 32'd0);

    // Write to grid 15 while grid 3 streams.
    ga = gm;
`ifndef TM1640_SHADOW_EN
    ga[15] = 8'hAA;
`endif
    push_frame(16, ga, 8'h8F);
    en0 = 1'b1;
    wait_rx(0, 5, "late write wait");
    do_write(4'd15, 8'hAA);
    push_frame(16, gm, 8'h8F);
    drain(0, "late write");
    en0 = 1'b0;
    repeat (80) @(negedge clk);
    check("late write idle", {31'd0, act0}, 32'd0);

    // Single-grid instance.
    do_write(4'd0, 8'h3C);
    do_write(4'd4, 8'hEE);
    brightness = 3'd2; display_on = 1'b1;
    base_l = lat1; base_f = fdn1;
    exp_q.push_back({8'h40, 1'b1});
    exp_q.push_back({8'hC0, 1'b0});
    exp_q.push_back({8'h3C, 1'b1});
    exp_q.push_back({8'h8A, 1'b1});
    en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    drain(1, "one grid");
    repeat (20) @(negedge clk);
    check("one grid latches", lat1 - base_l, 3);
    check("one grid frame_done", fdn1 - base_f, 1);
    check("one grid idle", {31'd0, act1}, 32'd0);

    // Reset in the middle of the grid stream.
    en0 = 1'b1;
    wait_rx(0, 6, "rst wait");
    rst = 1'b1;
    en0 = 1'b0;
    @(negedge clk);
    check("mid rst latch", {31'd0, drv0.tm_latch}, 32'd0);
    check("mid rst data", {24'd0, drv0.tm_data}, 32'd0);
    check("mid rst stop", {31'd0, drv0.tm_stop}, 32'd0);
    check("mid rst active", {31'd0, act0}, 32'd0);
    check("mid rst frame_done", {31'd0, fd0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rp0 = wp0;
    for (int i = 0; i < 16; i++) gm[i] = 8'h00;
    push_frame(16, gm, 8'h8A);
    en0 = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
    drain(0, "post rst");
    repeat (80) @(negedge clk);
    check("post rst idle", {31'd0, act0}, 32'd0);

    check("protocol inst0", viol0, 0);
    check("protocol inst1", viol1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
